kypd_scanner: RTL and testbench



---
 rtl/kypd_scanner.sv | 116 +++++++++++
 tb/tb_kypd_scanner.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kypd_scanner.sv
// kypd_scanner: 4x4 keypad column scanner with sweep-level debounce, ghost rejection
// and a valid/ack key report with sticky overrun.
module kypd_scanner #(
   parameter int SCAN_TICKS     = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       pb_clk,
   input  logic       pb_reset,
   input  logic [3:0] kypd_row,
   output logic [3:0] kypd_col,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_held,
   output logic       overrun
);
   localparam int TW = $clog2(SCAN_TICKS);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [4:0] NONE = 5'h10;
   // Key codes packed by snapshot index {col, row}, index 0 in the low nibble
   localparam logic [63:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

   logic [TW-1:0] tick_q, tick_d;
   logic [1:0] col_idx_q, col_idx_d;
   logic [3:0] col_q, col_d;
   logic [3:0] row_s1_q, row_s2_q;
   logic [15:0] snap_q, snap_d;
   logic eval_q, eval_d;
   logic [4:0] prev_q, prev_d;
   logic [4:0] stable_q, stable_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0] code_q, code_d;
   logic valid_q, valid_d;
   logic held_q, held_d;
   logic ovr_q, ovr_d;
   logic tc, accept, press;
   logic [4:0] ones, cand;
   logic [3:0] idx;

   always_comb begin
      ones = '0;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         ones = ones + 5'(snap_q[i]);
         if (snap_q[i]) idx = 4'(i);
      end
   end

   assign tc = tick_q == TICK_LAST;
   // More than one pressed contact in a sweep is treated as no key at all
   assign cand = (ones == 5'd1) ? {1'b0, KEY_MAP[{idx, 2'b00} +: 4]} : NONE;

   always_comb begin
      tick_d = tc ? '0 : tick_q + 1'b1;
      col_idx_d = tc ? col_idx_q + 2'd1 : col_idx_q;
      col_d = ~(4'b0001 << col_idx_d);
      eval_d = tc && (col_idx_q == 2'd3);
      snap_d = eval_q ? '0 : snap_q;
      if (tc) snap_d[{col_idx_q, 2'b00} +: 4] = ~row_s2_q;
   end

   always_comb begin
      cnt_d = !eval_q ? cnt_q : (cand != prev_q) ? CNT_ONE : (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      prev_d = eval_q ? cand : prev_q;
      accept = eval_q && (cnt_d == CNT_MAX) && (cand != stable_q);
      stable_d = accept ? cand : stable_q;
      press = accept && (cand != NONE);
      held_d = stable_d != NONE;
      valid_d = press || (valid_q && !key_ack);
      code_d = (press && (!valid_q || key_ack)) ? cand[3:0] : code_q;
      ovr_d = (valid_q && key_ack) ? 1'b0 : (press && valid_q) ? 1'b1 : ovr_q;
   end

   always_ff @(posedge pb_clk or posedge pb_reset) begin
      if (pb_reset) begin
         tick_q <= '0;
         col_idx_q <= '0;
         col_q <= 4'b1110;
         row_s1_q <= 4'hF;
         row_s2_q <= 4'hF;
         snap_q <= '0;
         eval_q <= 1'b0;
         prev_q <= NONE;
         stable_q <= NONE;
         cnt_q <= '0;
         code_q <= '0;
         valid_q <= 1'b0;
         held_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         tick_q <= tick_d;
         col_idx_q <= col_idx_d;
         col_q <= col_d;
         row_s1_q <= kypd_row;
         row_s2_q <= row_s1_q;
         snap_q <= snap_d;
         eval_q <= eval_d;
         prev_q <= prev_d;
         stable_q <= stable_d;
         cnt_q <= cnt_d;
         code_q <= code_d;
         valid_q <= valid_d;
         held_q <= held_d;
         ovr_q <= ovr_d;
      end
   end

   assign kypd_col = col_q;
   assign key_code = code_q;
   assign key_valid = valid_q;
   assign key_held = held_q;
   assign overrun = ovr_q;
endmodule

// File: tb/tb_kypd_scanner.sv
// tb_kypd_scanner: drives a physical 4x4 keypad model against kypd_scanner and
// checks outputs once per sweep against a sweep-level reference model.
module tb_kypd_scanner;
   localparam int ST = 4;
   localparam int DS = 2;
   localparam int NONE = 16;
   localparam logic [3:0] LAYOUT [4][4] = '{'{4'h1, 4'h2, 4'h3, 4'hA},
                                           '{4'h4, 4'h5, 4'h6, 4'hB},
                                           '{4'h7, 4'h8, 4'h9, 4'hC},
                                           '{4'h0, 4'hF, 4'hE, 4'hD}};

   logic pb_clk = 1'b0;
   logic pb_reset = 1'b1;
   logic [3:0] kypd_row;
   logic [3:0] kypd_col;
   logic [3:0] key_code;
   logic key_valid;
   logic key_ack = 1'b0;
   logic key_held;
   logic overrun;
   logic [15:0] pressed = '0;

   int checks = 0;
   int errors = 0;

   int m_prev, m_cnt, m_stable;
   logic [3:0] m_code;
   bit m_valid, m_ov;

   kypd_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DS)) dut (
      .pb_clk(pb_clk),
      .pb_reset(pb_reset),
      .kypd_row(kypd_row),
      .kypd_col(kypd_col),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_ack(key_ack),
      .key_held(key_held),
      .overrun(overrun)
   );

   always #5 pb_clk = ~pb_clk;

   // Pressed key shorts its row to its column; a low column pulls that row low
   always_comb begin
      kypd_row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[LAYOUT[r][c]] && !kypd_col[c]) kypd_row[r] = 1'b0;
   end

   task automatic model_reset();
      m_prev = NONE;
      m_cnt = 0;
      m_stable = NONE;
      m_code = 4'h0;
      m_valid = 1'b0;
      m_ov = 1'b0;
   endtask

   // One full sweep of held keys, with an optional ack coinciding with its evaluation
   task automatic model_sweep(input logic [15:0] keys, input bit ack);
      int cand;
      bit ev, v0;
      cand = NONE;
      if ($countones(keys) == 1)
         for (int k = 0; k < 16; k++)
            if (keys[k]) cand = k;
      m_cnt = (cand == m_prev) ? ((m_cnt < DS) ? m_cnt + 1 : DS) : 1;
      m_prev = cand;
      ev = 1'b0;
      if (m_cnt == DS && cand != m_stable) begin
         m_stable = cand;
         ev = cand != NONE;
      end
      v0 = m_valid;
      if (v0 && ack) begin
         m_valid = 1'b0;
         m_ov = 1'b0;
      end
      if (ev) begin
         if (!v0 || ack) begin
            m_code = 4'(cand);
            m_valid = 1'b1;
         end else m_ov = 1'b1;
      end
   endtask

   // Entered one cycle into column 0; leaves one cycle into column 0 of the next sweep
   task automatic step(input logic [15:0] keys, input bit ack);
      pressed = keys;
      repeat (4 * ST - 1) @(posedge pb_clk);
      #1 key_ack = ack;
      @(posedge pb_clk);
      #1 key_ack = 1'b0;
      model_sweep(keys, ack);
   endtask

   task automatic test_reset();
      pb_reset = 1'b1;
      @(posedge pb_clk);
      #2;
      checks++;
      if ({kypd_col, key_code, key_valid, key_held, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
         errors++;
         $display("FAIL reset: got col=%b code=%h v/h/o=%b%b%b, want col=1110 code=0 v/h/o=000",
                  kypd_col, key_code, key_valid, key_held, overrun);
      end
      @(posedge pb_clk);
      #1 pb_reset = 1'b0;
      model_reset();
   endtask

   task automatic test_columns();
      logic [3:0] exp_col;
      for (int i = 0; i < 40 * ST; i++) begin
         exp_col = ~(4'b0001 << ((i / ST) % 4));
         checks++;
         if ({kypd_col, key_valid, key_held, overrun} !== {exp_col, 3'b000}) begin
            errors++;
            $display("FAIL columns cycle %0d: got col=%b v/h/o=%b%b%b, want col=%b v/h/o=000",
                     i, kypd_col, key_valid, key_held, overrun, exp_col);
         end
         @(posedge pb_clk);
         #1;
      end
      @(posedge pb_clk);
      #1;
      for (int i = 0; i < 10; i++) model_sweep(16'h0, 1'b0);
   endtask

   task automatic test_single_press();
      logic [15:0] ks [8] = '{16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0020, 16'h0000, 16'h0000};
      bit ak [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      for (int i = 0; i < 8; i++) begin
         step(ks[i], ak[i]);
         checks++;
         if ({key_valid, key_held, overrun, key_code, kypd_col} !== {m_valid, m_stable != NONE, m_ov, m_code, 4'b1110}) begin
            errors++;
            $display("FAIL single_press sweep %0d: got v/h/o=%b%b%b code=%h col=%b, want %b%b%b code=%h col=1110",
                     i, key_valid, key_held, overrun, key_code, kypd_col, m_valid, m_stable != NONE, m_ov, m_code);
         end
         if (i == 1 || i == 3) begin
            checks++;
            if ({key_valid, key_held, key_code} !== {2'b11, 4'h5}) begin
               errors++;
               $display("FAIL single_press_key5 sweep %0d: got v/h=%b%b code=%h, want v/h=11 code=5",
                        i, key_valid, key_held, key_code);
            end
         end
         if (i == 4 || i == 5 || i == 7) begin
            checks++;
            if (key_valid !== 1'b0) begin
               errors++;
               $display("FAIL single_press_no_event sweep %0d: got valid=%b, want 0", i, key_valid);
            end
         end
      end
      checks++;
      if (key_held !== 1'b0) begin
         errors++;
         $display("FAIL single_press_release: got held=%b, want 0", key_held);
      end
   endtask

   task automatic test_bounce();
      logic [15:0] ks [4] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
      for (int i = 0; i < 4; i++) begin
         step(ks[i], 1'b0);
         checks++;
         if ({key_valid, key_held, overrun, key_code} !== {m_valid, m_stable != NONE, m_ov, m_code}) begin
            errors++;
            $display("FAIL bounce sweep %0d: got v/h/o=%b%b%b code=%h, want %b%b%b code=%h",
                     i, key_valid, key_held, overrun, key_code, m_valid, m_stable != NONE, m_ov, m_code);
         end
         checks++;
         if ({key_valid, key_held} !== 2'b00) begin
            errors++;
            $display("FAIL bounce_quiet sweep %0d: got v/h=%b%b, want 00", i, key_valid, key_held);
         end
      end
   endtask

   task automatic test_ghost();
      logic [15:0] ks [8] = '{16'h0006, 16'h0006, 16'h0006, 16'h0006, 16'h0004, 16'h0004, 16'h0000, 16'h0000};
      bit ak [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
      for (int i = 0; i < 8; i++) begin
         step(ks[i], ak[i]);
         checks++;
         if ({key_valid, key_held, overrun, key_code} !== {m_valid, m_stable != NONE, m_ov, m_code}) begin
            errors++;
            $display("FAIL ghost sweep %0d: got v/h/o=%b%b%b code=%h, want %b%b%b code=%h",
                     i, key_valid, key_held, overrun, key_code, m_valid, m_stable != NONE, m_ov, m_code);
         end
         if (i == 3 || i == 5) begin
            checks++;
            if ({key_valid, key_code} !== ((i == 3) ? {1'b0, key_code} : {1'b1, 4'h2})) begin
               errors++;
               $display("FAIL ghost_event sweep %0d: got valid=%b code=%h", i, key_valid, key_code);
            end
         end
      end
   endtask

   task automatic test_overrun();
      logic [15:0] ks [8] = '{16'h0008, 16'h0008, 16'h0000, 16'h0000, 16'h0200, 16'h0200, 16'h0000, 16'h0000};
      bit ak [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
      for (int i = 0; i < 8; i++) begin
         step(ks[i], ak[i]);
         checks++;
         if ({key_valid, key_held, overrun, key_code} !== {m_valid, m_stable != NONE, m_ov, m_code}) begin
            errors++;
            $display("FAIL overrun sweep %0d: got v/h/o=%b%b%b code=%h, want %b%b%b code=%h",
                     i, key_valid, key_held, overrun, key_code, m_valid, m_stable != NONE, m_ov, m_code);
         end
      end
      checks++;
      if ({key_valid, overrun, key_code} !== {2'b00, 4'h3}) begin
         errors++;
         $display("FAIL overrun_ack: got v/o=%b%b code=%h, want v/o=00 code=3", key_valid, overrun, key_code);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] ks [6] = '{16'h2000, 16'h2000, 16'h0200, 16'h0200, 16'h0080, 16'h0080};
      bit ak [6] = '{0, 0, 0, 0, 0, 1};
      step(16'h0008, 1'b0);
      step(16'h0008, 1'b0);
      step(16'h2000, 1'b0);
      checks++;
      if ({key_valid, key_code} !== {1'b1, 4'h3}) begin
         errors++;
         $display("FAIL reset_mid_pre: got valid=%b code=%h, want valid=1 code=3", key_valid, key_code);
      end
      #5 pb_reset = 1'b1;
      #1;
      checks++;
      if ({kypd_col, key_code, key_valid, key_held, overrun} !== {4'b1110, 4'h0, 3'b000}) begin
         errors++;
         $display("FAIL reset_mid_async: got col=%b code=%h v/h/o=%b%b%b, want col=1110 code=0 v/h/o=000",
                  kypd_col, key_code, key_valid, key_held, overrun);
      end
      @(posedge pb_clk);
      @(posedge pb_clk);
      #1 pb_reset = 1'b0;
      model_reset();
      @(posedge pb_clk);
      #1;
      for (int i = 0; i < 6; i++) begin
         step(ks[i], ak[i]);
         checks++;
         if ({key_valid, key_held, overrun, key_code} !== {m_valid, m_stable != NONE, m_ov, m_code}) begin
            errors++;
            $display("FAIL reset_mid sweep %0d: got v/h/o=%b%b%b code=%h, want %b%b%b code=%h",
                     i, key_valid, key_held, overrun, key_code, m_valid, m_stable != NONE, m_ov, m_code);
         end
      end
      checks++;
      if ({key_valid, overrun, key_code} !== {2'b10, 4'h7}) begin
         errors++;
         $display("FAIL reset_mid_ack_press: got v/o=%b%b code=%h, want v/o=10 code=7", key_valid, overrun, key_code);
      end
   endtask

   task automatic test_random();
      logic [15:0] keys;
      int kind, k1, k2, hold;
      for (int n = 0; n < 40; n++) begin
         kind = $urandom_range(0, 3);
         k1 = $urandom_range(0, 15);
         k2 = (k1 + $urandom_range(1, 15)) % 16;
         keys = (kind == 0) ? 16'h0 : (kind == 3) ? ((16'h1 << k1) | (16'h1 << k2)) : (16'h1 << k1);
         hold = $urandom_range(1, 4);
         for (int s = 0; s < hold; s++) begin
            step(keys, $urandom_range(0, 2) == 0);
            checks++;
            if ({key_valid, key_held, overrun, key_code} !== {m_valid, m_stable != NONE, m_ov, m_code}) begin
               errors++;
               $display("FAIL random iter %0d sweep %0d keys=%h: got v/h/o=%b%b%b code=%h, want %b%b%b code=%h",
                        n, s, keys, key_valid, key_held, overrun, key_code, m_valid, m_stable != NONE, m_ov, m_code);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_columns();
      test_single_press();
      test_bounce();
      test_ghost();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
